display_mode_ctrl: RTL
======================

# display_mode_ctrl

Frame-synchronous controller for the VGA colorizer's layer select. It debounces the two display-mode slide switches and holds each mode change until a vertical-blank boundary. It then forces the output black for a fixed number of whole frames and commits the new mode. It drives registered layer enables into the colorizer, so layer composition never changes mid-frame.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: `clk` cycles a synchronized switch value must hold before it is accepted; must be ≥ 2.
- `BLANK_FRAMES`, default 2: whole frames forced black per transition; 0 = commit with no blanking.
- `AUTO_FRAMES`, default 120: frames per step in auto-cycle; only used with `DISPLAY_AUTOCYCLE_EN`.
- `clk` in 1: pixel-domain clock.
- `resetn` in 1: synchronous, active-low reset (already decided).
- `mode_sw` in 2: raw `{switch[15],switch[14]}`, asynchronous.
- `frame_tick` in 1: one-cycle pulse at start of vertical blank.
- `auto_en` in 1: auto-cycle enable; present only with `DISPLAY_AUTOCYCLE_EN`.
- `mode` out 2: committed display mode.
- `blank` out 1: colorizer forces 12'h000 while high.
- `title_en`, `icon_en`, `icon2_en`, `world_en` out 1 each: layer enables decoded from `mode`.
- `busy` out 1: high in PEND or BLANK.
- `mode_change` out 1: one-cycle pulse on the commit cycle.

## Operation
- **Input synchronizer.** `mode_sw` passes through a 2-FF synchronizer.
- **Debouncer.**
  - A counter clears whenever the synchronized value ≠ the candidate; the candidate is then reloaded.
  - When the counter reaches DEBOUNCE_CYCLES−1, the candidate is copied to `stable_mode`.
- **Mode decode.** All enables are registered and update in the same cycle as `mode`.
  - 00: title + world.
  - 01: title + icon + world.
  - 10: title + icon2 + world.
  - 11: raw world map only.
- **FSM states:** IDLE, PEND, BLANK.
  - **IDLE:** if `stable_mode` ≠ `mode`, latch `target` ← `stable_mode` and go to PEND.
  - **PEND:** `target` tracks `stable_mode`. If `stable_mode` = `mode`, return to IDLE with no blanking. On `frame_tick`:
    - BLANK_FRAMES = 0: commit and go to IDLE.
    - Otherwise: `blank` ← 1, `fcnt` ← 0, go to BLANK.
  - **BLANK:** `target` keeps tracking `stable_mode`; the frame count is not restarted. On each `frame_tick`:
    - If `fcnt` = BLANK_FRAMES−1: commit and go to IDLE.
    - Otherwise: `fcnt`++.
  - **Commit:** `mode` ← `target`, enables update, `blank` ← 0, `mode_change` pulses, all in one cycle.
  - A BLANK episode whose `target` equals the current `mode` still completes its blank frames and still pulses `mode_change`.
- **Simultaneous events.** A `frame_tick` in the same cycle that `stable_mode` updates is evaluated against the old `stable_mode`.
- **Reset values.**
  - `mode` = 00, `title_en` = 1, `icon_en` = 0, `icon2_en` = 0, `world_en` = 1.
  - `blank` = 0, `busy` = 0, `mode_change` = 0.
  - `stable_mode`, candidate and synchronizer = 00; counters = 0.
- **Reset during operation.** Reset asserted in PEND or BLANK aborts the transition and returns all outputs to reset values on the next edge.

## Timing
- **Switch to stable.** A clean switch edge reaches `stable_mode` after 2 sync cycles + DEBOUNCE_CYCLES cycles.
- **Stable to PEND.** `busy` rises 1 cycle after `stable_mode` changes.
- **Entering blank.** `blank` rises the cycle after the first `frame_tick` seen in PEND.
- **Commit.** Occurs the cycle after the (BLANK_FRAMES+1)-th `frame_tick` counted from PEND entry.
  - `busy` falls in that same cycle.
  - With BLANK_FRAMES = 0, commit occurs the cycle after the first tick.
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES never reaches `stable_mode`.
- **Pipeline.** All outputs are registered; no combinational path from any input.

## Configuration
- **With `DISPLAY_AUTOCYCLE_EN`:**
  - Adds the `auto_en` port and a frame counter that counts `frame_tick` only while `auto_en` = 1 and the FSM is in IDLE.
  - At AUTO_FRAMES ticks the counter sets `target` ← `mode`+1 (11 wraps to 00), goes to PEND, and clears.
  - A `stable_mode` change has priority over the auto request in the same cycle and clears the counter.
  - Once the switches have moved, the FSM holds `mode` at the auto-stepped value as long as `stable_mode` = `mode`.
- **Without it:** no `auto_en` port, no counter, and `AUTO_FRAMES` is ignored.

## Structure
- **Package `display_pkg`:**
  - Mode constants `MODE_TITLE_MAP` = 00, `MODE_TITLE_ICON` = 01, `MODE_TITLE_ICON2` = 10, `MODE_WORLD_RAW` = 11.
  - FSM state encodings.
- **Sub-module `sw_debounce`:** a 2-bit synchronizer plus debouncer, parameterized by DEBOUNCE_CYCLES, output `stable`.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4, BLANK_FRAMES = 2, and `frame_tick` every 50 cycles.
- Reset held 3 cycles with `mode_sw` = 11 → `mode` = 00, `title_en` = 1, `world_en` = 1, `blank` = 0; `busy` rises 7 cycles after release.
- `mode_sw` 00→01 → `busy` rises; `blank` rises after the next tick and lasts 2 frames; on the commit cycle `mode` = 01, `icon_en` = 1, and `mode_change` pulses once.
- 2-cycle glitch on `mode_sw` → `stable_mode`, `busy` and `mode` unchanged.
- Change to 10, then to 11 during BLANK → commit lands on the original tick schedule with `mode` = 11, all enables 0 except `world_en`.
- Change to 01 then back to 00 before the first tick → `busy` falls, `blank` never rises, no `mode_change`.
- Macro on, AUTO_FRAMES = 3, `auto_en` = 1 → `mode` steps 00→01→10→11→00; reset mid-BLANK → reset values on the next edge.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the display-mode controller.
//   - MODE_* : 2-bit display mode encodings driven by the slide switches
//   - state_t: controller FSM state encoding
//   - layer_decode(): mode -> {title, icon, icon2, world} layer enables
package display_pkg;

  localparam logic [1:0] MODE_TITLE_MAP   = 2'b00;
  localparam logic [1:0] MODE_TITLE_ICON  = 2'b01;
  localparam logic [1:0] MODE_TITLE_ICON2 = 2'b10;
  localparam logic [1:0] MODE_WORLD_RAW   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Returns {title_en, icon_en, icon2_en, world_en}.
  function automatic logic [3:0] layer_decode(input logic [1:0] m);
    logic [3:0] en;
    case (m)
      MODE_TITLE_MAP:   en = 4'b1001;
      MODE_TITLE_ICON:  en = 4'b1101;
      MODE_TITLE_ICON2: en = 4'b1011;
      default:          en = 4'b0001;  // MODE_WORLD_RAW
    endcase
    return en;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchronizer plus debouncer for the 2-bit mode switches.
// Ports:
//   i_clk     - pixel-domain clock
//   i_resetn  - synchronous active-low reset
//   i_sw      - raw asynchronous switch value
//   o_stable  - debounced value; updates once the synchronized value has
//               held for DEBOUNCE_CYCLES consecutive cycles (>= 2)
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [1:0] i_sw,
  output logic [1:0] o_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_stable;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sync1  <= 2'b00;
      r_sync2  <= 2'b00;
      r_cand   <= 2'b00;
      r_cnt    <= '0;
      r_stable <= 2'b00;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + CW'(1);
        // The copy lands on the same edge the counter reaches its last
        // value, so a value held for DEBOUNCE_CYCLES samples is accepted.
        if (r_cnt == CNT_PRE) begin
          r_stable <= r_cand;
        end
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: frame-synchronous layer-select controller for the VGA
// colorizer. Debounced mode changes wait for a vertical-blank tick, the
// output is forced black for BLANK_FRAMES whole frames, then the new mode
// and its layer enables commit together.
// Optional feature macro: DISPLAY_AUTOCYCLE_EN (adds i_auto_en and an
// AUTO_FRAMES-per-step automatic mode cycler).
// Ports:
//   i_clk, i_resetn (sync, active-low), i_mode_sw (raw switches),
//   i_frame_tick (start of vblank pulse), i_auto_en (macro only)
//   o_mode, o_blank, o_title_en, o_icon_en, o_icon2_en, o_world_en,
//   o_busy (PEND or BLANK), o_mode_change (commit pulse); all registered.
module display_mode_ctrl
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLANK_FRAMES    = 2,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [1:0] i_mode_sw,
  input  logic       i_frame_tick,
`ifdef DISPLAY_AUTOCYCLE_EN
  input  logic       i_auto_en,
`endif
  output logic [1:0] o_mode,
  output logic       o_blank,
  output logic       o_title_en,
  output logic       o_icon_en,
  output logic       o_icon2_en,
  output logic       o_world_en,
  output logic       o_busy,
  output logic       o_mode_change
);

  localparam int FCW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  logic [1:0]     w_stable;
  logic           w_follow;
  logic [1:0]     w_target_next;

  state_t         r_state;
  logic [1:0]     r_target;
  logic [FCW-1:0] r_fcnt;
  logic [1:0]     r_mode;
  logic [3:0]     r_layers;
  logic           r_blank;
  logic           r_busy;
  logic           r_mode_change;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk   (i_clk),
    .i_resetn(i_resetn),
    .i_sw    (i_mode_sw),
    .o_stable(w_stable)
  );

`ifdef DISPLAY_AUTOCYCLE_EN
  localparam int ACW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [ACW-1:0] ACNT_LAST = ACW'(AUTO_FRAMES - 1);

  logic [ACW-1:0] r_acnt;
  logic           r_auto_owned;
  logic [1:0]     r_stable_prev;
  logic           w_sw_change;

  assign w_sw_change = (w_stable != r_stable_prev);
  // After an auto step the switches no longer match the mode; they only
  // regain control once they actually move.
  assign w_follow    = !r_auto_owned || w_sw_change;
`else
  assign w_follow    = 1'b1;
`endif

  // While a transition is in flight the target tracks the debounced switches,
  // so a commit always uses the freshest switch value.
  assign w_target_next = ((r_state != ST_IDLE) && w_follow) ? w_stable : r_target;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state       <= ST_IDLE;
      r_target      <= MODE_TITLE_MAP;
      r_fcnt        <= '0;
      r_mode        <= MODE_TITLE_MAP;
      r_layers      <= layer_decode(MODE_TITLE_MAP);
      r_blank       <= 1'b0;
      r_busy        <= 1'b0;
      r_mode_change <= 1'b0;
`ifdef DISPLAY_AUTOCYCLE_EN
      r_acnt        <= '0;
      r_auto_owned  <= 1'b0;
      r_stable_prev <= 2'b00;
`endif
    end else begin
      r_mode_change <= 1'b0;
      r_target      <= w_target_next;
`ifdef DISPLAY_AUTOCYCLE_EN
      r_stable_prev <= w_stable;
      if (w_sw_change) begin
        r_acnt       <= '0;
        r_auto_owned <= 1'b0;
      end
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_follow && (w_stable != r_mode)) begin
            r_target <= w_stable;
            r_state  <= ST_PEND;
            r_busy   <= 1'b1;
          end
`ifdef DISPLAY_AUTOCYCLE_EN
          else if (i_auto_en && i_frame_tick && !w_sw_change) begin
            if (r_acnt == ACNT_LAST) begin
              r_target     <= r_mode + 2'd1;
              r_state      <= ST_PEND;
              r_busy       <= 1'b1;
              r_acnt       <= '0;
              r_auto_owned <= 1'b1;
            end else begin
              r_acnt <= r_acnt + ACW'(1);
            end
          end
`endif
        end
        ST_PEND: begin
          if (w_follow && (w_stable == r_mode)) begin
            // Switches returned before any tick: cancel silently.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (i_frame_tick) begin
            if (BLANK_FRAMES == 0) begin
              r_mode        <= w_target_next;
              r_layers      <= layer_decode(w_target_next);
              r_mode_change <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= ST_IDLE;
            end else begin
              r_blank <= 1'b1;
              r_fcnt  <= '0;
              r_state <= ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          // No abort here: a started blank episode always runs to commit.
          if (i_frame_tick) begin
            if (r_fcnt == FCNT_LAST) begin
              r_mode        <= w_target_next;
              r_layers      <= layer_decode(w_target_next);
              r_mode_change <= 1'b1;
              r_blank       <= 1'b0;
              r_busy        <= 1'b0;
              r_state       <= ST_IDLE;
            end else begin
              r_fcnt <= r_fcnt + FCW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_blank <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mode        = r_mode;
  assign o_blank       = r_blank;
  assign o_title_en    = r_layers[3];
  assign o_icon_en     = r_layers[2];
  assign o_icon2_en    = r_layers[1];
  assign o_world_en    = r_layers[0];
  assign o_busy        = r_busy;
  assign o_mode_change = r_mode_change;

endmodule
